// File: rtl/riscvvec_mem_arb_pkg.sv
// ============================================================================
// Module      : riscvvec_mem_arb_pkg
// Description : Shared constants and message-size helpers for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscvvec_mem_arb_pkg;

    localparam logic ARB_PORT_IMEM = 1'b0;
    localparam logic ARB_PORT_DMEM = 1'b1;

    // vc memory message layout: {type, addr, len, data} / {type, len, data}
    function automatic int unsigned vc_mem_req_msg_sz(input int unsigned addr_sz,
                                                      input int unsigned data_sz);
        return 1 + addr_sz + $clog2(data_sz / 8) + data_sz;
    endfunction

    function automatic int unsigned vc_mem_resp_msg_sz(input int unsigned data_sz);
        return 1 + $clog2(data_sz / 8) + data_sz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/riscvvec_mem_arb_if.sv
// ============================================================================
// Module      : riscvvec_mem_arb_if
// Description : Bus bundle for both core-side ports and the shared memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscvvec_mem_arb_if
    import riscvvec_mem_arb_pkg::*;
#(
    parameter int unsigned p_addr_sz = 32,
    parameter int unsigned p_data_sz = 32
);
    localparam int unsigned c_req_w  = vc_mem_req_msg_sz(p_addr_sz, p_data_sz);
    localparam int unsigned c_resp_w = vc_mem_resp_msg_sz(p_data_sz);

    logic [c_req_w-1:0]  memreq0_msg;
    logic                memreq0_val;
    logic                memreq0_rdy;
    logic [c_resp_w-1:0] memresp0_msg;
    logic                memresp0_val;

    logic [c_req_w-1:0]  memreq1_msg;
    logic                memreq1_val;
    logic                memreq1_rdy;
    logic [c_resp_w-1:0] memresp1_msg;
    logic                memresp1_val;

    logic [c_req_w-1:0]  memreq_msg;
    logic                memreq_val;
    logic                memreq_rdy;
    logic [c_resp_w-1:0] memresp_msg;
    logic                memresp_val;
    logic                memresp_rdy;

    logic                err;

    // Arbiter view
    modport slave (
        input  memreq0_msg, memreq0_val, output memreq0_rdy,
        output memresp0_msg, memresp0_val,
        input  memreq1_msg, memreq1_val, output memreq1_rdy,
        output memresp1_msg, memresp1_val,
        output memreq_msg, memreq_val, input memreq_rdy,
        input  memresp_msg, memresp_val, output memresp_rdy,
        output err
    );

    // Core / memory environment view
    modport master (
        output memreq0_msg, memreq0_val, input memreq0_rdy,
        input  memresp0_msg, memresp0_val,
        output memreq1_msg, memreq1_val, input memreq1_rdy,
        input  memresp1_msg, memresp1_val,
        input  memreq_msg, memreq_val, output memreq_rdy,
        output memresp_msg, memresp_val, input memresp_rdy,
        input  err
    );

endinterface

`default_nettype wire

// File: rtl/riscvvec_mem_arb_idq.sv
// ============================================================================
// Module      : riscvvec_mem_arb_idq
// Description : In-order FIFO of 1-bit port IDs for outstanding memory requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscvvec_mem_arb_idq #(
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enq_val,
    input  logic enq_bits,
    input  logic deq_val,
    output logic deq_bits,
    output logic full,
    output logic empty
);
    localparam int unsigned c_ptr_w = $clog2(p_max_outstanding);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(p_max_outstanding);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [p_max_outstanding-1:0] slots_q, slots_d;
    logic [c_ptr_w-1:0]           head_q, head_d;
    logic [c_ptr_w-1:0]           tail_q, tail_d;
    logic [c_cnt_w-1:0]           cnt_q, cnt_d;

    // Depth is a power of two, so pointers wrap by natural overflow
    always_comb begin
        slots_d = slots_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (enq_val) begin
            slots_d[tail_q] = enq_bits;
            tail_d          = tail_q + c_ptr_one;
        end
        if (deq_val) begin
            head_d = head_q + c_ptr_one;
        end
        case ({enq_val, deq_val})
            2'b10:   cnt_d = cnt_q + c_cnt_one;
            2'b01:   cnt_d = cnt_q - c_cnt_one;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            slots_q <= slots_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deq_bits = slots_q[head_q];
    assign full     = (cnt_q == c_depth);
    assign empty    = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/riscvvec_mem_arb.sv
// ============================================================================
// Module      : riscvvec_mem_arb
// Description : Round-robin 2:1 memory arbiter with in-order response steering.
//               Optional counters enabled by RISCVVEC_MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscvvec_mem_arb
    import riscvvec_mem_arb_pkg::*;
#(
    parameter int unsigned p_max_outstanding = 4
) (
    input  logic               clk,
    input  logic               reset,
    riscvvec_mem_arb_if.slave  bus
);
    logic prio_q, prio_d;
    logic err_q, err_d;
    logic w_any;
    logic w_gnt;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_fire;
    logic w_pop;

    always_comb begin
        w_any = bus.memreq0_val | bus.memreq1_val;
        if (bus.memreq0_val && bus.memreq1_val) begin
            w_gnt = prio_q;
        end else if (bus.memreq1_val) begin
            w_gnt = ARB_PORT_DMEM;
        end else begin
            w_gnt = ARB_PORT_IMEM;
        end
    end

    // Full blocks issue regardless of a same-cycle pop, keeping memreq_val off the response path
    assign bus.memreq_val  = w_any & ~w_full & ~reset;
    assign bus.memreq_msg  = (w_gnt == ARB_PORT_DMEM) ? bus.memreq1_msg : bus.memreq0_msg;
    assign bus.memreq0_rdy = bus.memreq_val & bus.memreq_rdy & (w_gnt == ARB_PORT_IMEM);
    assign bus.memreq1_rdy = bus.memreq_val & bus.memreq_rdy & (w_gnt == ARB_PORT_DMEM);
    assign w_fire          = bus.memreq_val & bus.memreq_rdy;

    assign w_pop            = bus.memresp_val & ~w_empty & ~reset;
    assign bus.memresp0_val = w_pop & (w_head == ARB_PORT_IMEM);
    assign bus.memresp1_val = w_pop & (w_head == ARB_PORT_DMEM);
    assign bus.memresp0_msg = bus.memresp_msg;
    assign bus.memresp1_msg = bus.memresp_msg;
    assign bus.memresp_rdy  = ~reset;
    assign bus.err          = err_q;

    assign prio_d = w_fire ? ~w_gnt : prio_q;
    assign err_d  = err_q | (bus.memresp_val & w_empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= ARB_PORT_IMEM;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

    riscvvec_mem_arb_idq #(
        .p_max_outstanding (p_max_outstanding)
    ) u_idq (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (w_fire),
        .enq_bits (w_gnt),
        .deq_val  (w_pop),
        .deq_bits (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

`ifdef RISCVVEC_MEM_ARB_STATS_EN
    logic [31:0] num_grant0;
    logic [31:0] num_grant1;
    logic [31:0] num_conflict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_grant0   <= '0;
            num_grant1   <= '0;
            num_conflict <= '0;
        end else begin
            if (w_fire && (w_gnt == ARB_PORT_IMEM)) num_grant0 <= num_grant0 + 32'd1;
            if (w_fire && (w_gnt == ARB_PORT_DMEM)) num_grant1 <= num_grant1 + 32'd1;
            if (bus.memreq0_val && bus.memreq1_val) num_conflict <= num_conflict + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscvvec_mem_arb.sv
// ============================================================================
// Module      : tb_riscvvec_mem_arb
// Description : Vector table, directed corner sequences and randomized run
//               against a queue-based reference model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscvvec_mem_arb;
    import riscvvec_mem_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int RW    = vc_mem_req_msg_sz(32, 32);
    localparam int SW    = vc_mem_resp_msg_sz(32);

    typedef struct {
        bit v0, v1, mrdy, rv;
        bit mval, rdy0, rdy1, rv0, rv1, err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscvvec_mem_arb_if #(.p_addr_sz(32), .p_data_sz(32)) bus ();

    riscvvec_mem_arb #(.p_max_outstanding(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding IDs in issue order, favoured port, sticky error
    bit q[$];
    bit m_prio;
    bit m_err;
    int m_g0, m_g1, m_cf;

    bit g, pop, e_mval, e_rdy0, e_rdy1, e_rv0, e_rv1;
    logic [RW-1:0] e_msg;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_prio = 1'b0;
        m_err  = 1'b0;
        m_g0 = 0; m_g1 = 0; m_cf = 0;
    endtask

    task automatic apply(input bit v0, input bit v1, input bit mrdy, input bit rv);
        bus.memreq0_val  = v0;
        bus.memreq1_val  = v1;
        bus.memreq_rdy   = mrdy;
        bus.memresp_val  = rv;
        bus.memreq0_msg  = RW'({$urandom(), $urandom(), $urandom()});
        bus.memreq1_msg  = RW'({$urandom(), $urandom(), $urandom()});
        bus.memresp_msg  = SW'({$urandom(), $urandom()});
    endtask

    // Settle, derive expectations from the model and compare every output
    task automatic eval();
        bit full;
        #3;
        full   = (q.size() == DEPTH);
        g      = (bus.memreq0_val && bus.memreq1_val) ? m_prio : bus.memreq1_val;
        e_mval = (bus.memreq0_val || bus.memreq1_val) && !full;
        e_rdy0 = e_mval && bus.memreq_rdy && !g;
        e_rdy1 = e_mval && bus.memreq_rdy && g;
        pop    = bus.memresp_val && (q.size() > 0);
        e_rv0  = pop && (q[0] == 1'b0);
        e_rv1  = pop && (q[0] == 1'b1);
        e_msg  = g ? bus.memreq1_msg : bus.memreq0_msg;
        chk("memreq_val", 128'(bus.memreq_val), 128'(e_mval));
        chk("memreq0_rdy", 128'(bus.memreq0_rdy), 128'(e_rdy0));
        chk("memreq1_rdy", 128'(bus.memreq1_rdy), 128'(e_rdy1));
        chk("memresp0_val", 128'(bus.memresp0_val), 128'(e_rv0));
        chk("memresp1_val", 128'(bus.memresp1_val), 128'(e_rv1));
        chk("memresp_rdy", 128'(bus.memresp_rdy), 128'(1'b1));
        chk("err", 128'(bus.err), 128'(m_err));
        chk("memresp0_msg", 128'(bus.memresp0_msg), 128'(bus.memresp_msg));
        chk("memresp1_msg", 128'(bus.memresp1_msg), 128'(bus.memresp_msg));
        if (e_mval) chk("memreq_msg", 128'(bus.memreq_msg), 128'(e_msg));
    endtask

    task automatic tick();
        if (bus.memreq0_val && bus.memreq1_val) m_cf++;
        if (bus.memresp_val && q.size() == 0) m_err = 1'b1;
        if (pop) void'(q.pop_front());
        if (e_mval && bus.memreq_rdy) begin
            q.push_back(g);
            m_prio = !g;
            if (g) m_g1++; else m_g0++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        reset = 1'b1;
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("rst_memreq_val", 128'(bus.memreq_val), 128'(1'b0));
        chk("rst_memresp_rdy", 128'(bus.memresp_rdy), 128'(1'b0));
        chk("rst_err", 128'(bus.err), 128'(1'b0));
        @(posedge clk);
        do_reset();

        // v0 v1 mrdy rv | mval rdy0 rdy1 rv0 rv1 err
        tbl[0] = '{1,0,1,0, 1,1,0,0,0,0};
        tbl[1] = '{1,1,1,0, 1,0,1,0,0,0};
        tbl[2] = '{1,1,1,0, 1,1,0,0,0,0};
        tbl[3] = '{0,0,1,1, 0,0,0,1,0,0};
        tbl[4] = '{0,0,1,1, 0,0,0,0,1,0};
        tbl[5] = '{0,1,0,1, 1,0,0,1,0,0};
        tbl[6] = '{1,1,1,0, 1,0,1,0,0,0};
        tbl[7] = '{0,0,1,1, 0,0,0,0,1,0};
        tbl[8] = '{0,0,1,1, 0,0,0,0,0,0};
        tbl[9] = '{1,0,1,0, 1,1,0,0,0,1};
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].v0, tbl[i].v1, tbl[i].mrdy, tbl[i].rv);
            eval();
            chk($sformatf("tbl%0d_mval", i), 128'(bus.memreq_val), 128'(tbl[i].mval));
            chk($sformatf("tbl%0d_rdy0", i), 128'(bus.memreq0_rdy), 128'(tbl[i].rdy0));
            chk($sformatf("tbl%0d_rdy1", i), 128'(bus.memreq1_rdy), 128'(tbl[i].rdy1));
            chk($sformatf("tbl%0d_rv0", i), 128'(bus.memresp0_val), 128'(tbl[i].rv0));
            chk($sformatf("tbl%0d_rv1", i), 128'(bus.memresp1_val), 128'(tbl[i].rv1));
            chk($sformatf("tbl%0d_err", i), 128'(bus.err), 128'(tbl[i].err));
            tick();
        end

        // Port 0 only: three reads, data 0xA/0xB/0xC returned in order
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0);
            bus.memreq0_msg = RW'({1'b0, 32'h100 + 32'(4 * i), 2'b00, 32'h0});
            eval();
            chk("p0_req_addr", 128'(bus.memreq_msg[65:34]), 128'(32'h100 + 32'(4 * i)));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b1);
            bus.memresp_msg = SW'({1'b0, 2'b00, 32'hA + 32'(i)});
            eval();
            chk("p0_resp_val", 128'(bus.memresp0_val), 128'(1'b1));
            chk("p0_resp_other", 128'(bus.memresp1_val), 128'(1'b0));
            chk("p0_resp_data", 128'(bus.memresp0_msg[31:0]), 128'(32'hA + 32'(i)));
            tick();
        end

        // Continuous conflict: grants alternate, responses follow issue order
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, 1'b1, i > 0);
            eval();
            chk("alt_rdy0", 128'(bus.memreq0_rdy), 128'(i % 2 == 0));
            chk("alt_rdy1", 128'(bus.memreq1_rdy), 128'(i % 2 == 1));
            if (i > 0) begin
                chk("alt_rv0", 128'(bus.memresp0_val), 128'((i - 1) % 2 == 0));
                chk("alt_rv1", 128'(bus.memresp1_val), 128'((i - 1) % 2 == 1));
            end
            tick();
        end

        // Full queue: 4 fire, 5th blocked; pop while full does not push; next cycle pushes
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0);
            eval();
            chk("fill_rdy0", 128'(bus.memreq0_rdy), 128'(1'b1));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0);
            eval();
            chk("full_mval", 128'(bus.memreq_val), 128'(1'b0));
            chk("full_rdy", 128'({bus.memreq0_rdy, bus.memreq1_rdy}), 128'(2'b00));
            tick();
        end
        apply(1'b1, 1'b0, 1'b1, 1'b1);
        eval();
        chk("full_pop_rv0", 128'(bus.memresp0_val), 128'(1'b1));
        chk("full_pop_mval", 128'(bus.memreq_val), 128'(1'b0));
        tick();
        apply(1'b1, 1'b0, 1'b1, 1'b0);
        eval();
        chk("after_pop_rdy0", 128'(bus.memreq0_rdy), 128'(1'b1));
        tick();

        // Reset mid-stream with 3 outstanding
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0);
            eval();
            tick();
        end
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_outs", 128'({bus.memreq_val, bus.memreq0_rdy, bus.memreq1_rdy,
                                 bus.memresp0_val, bus.memresp1_val, bus.memresp_rdy}), 128'(6'b0));
        @(posedge clk);
        #1;
        model_clear();
`ifdef RISCVVEC_MEM_ARB_STATS_EN
        chk("stat_rst", 128'({dut.num_grant0, dut.num_grant1, dut.num_conflict}), 128'(96'b0));
`endif
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0);
            eval();
            if (i == 0) chk("postrst_prio0", 128'(bus.memreq0_rdy), 128'(1'b1));
            chk("postrst_fire", 128'(bus.memreq_val), 128'(1'b1));
            tick();
        end

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rv;
            rv = (q.size() > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 59) == 0);
            apply(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, rv);
            eval();
            tick();
        end
`ifdef RISCVVEC_MEM_ARB_STATS_EN
        chk("stat_g0", 128'(dut.num_grant0), 128'(m_g0));
        chk("stat_g1", 128'(dut.num_grant1), 128'(m_g1));
        chk("stat_cf", 128'(dut.num_conflict), 128'(m_cf));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscvvec_mem_arb.md
# riscvvec_mem_arb

Two-to-one memory arbiter between the core's instruction (port 0) and data (port 1) memory interfaces and a single-port test memory. It merges both request streams with round-robin priority and tracks the issuing port of every in-flight request in an in-order ID queue. Each memory response is steered back to the port that issued the matching request. It sits between `riscv_Core` and a single-port `vc_TestRandDelayMem`, so the core can be exercised against one shared memory port.

## Interface
- `p_addr_sz`, 32, address bits in the request message.
- `p_data_sz`, 32, data bits in request and response messages.
- `p_max_outstanding`, 4, ID-queue depth; must be a power of two ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memreq0_msg`  in  `VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)`  imem request.
- `memreq0_val`  in  1  imem request valid.
- `memreq0_rdy`  out  1  imem request accepted.
- `memresp0_msg`  out  `VC_MEM_RESP_MSG_SZ(p_data_sz)`  imem response.
- `memresp0_val`  out  1  imem response valid.
- `memreq1_msg`, `memreq1_val`, `memreq1_rdy`, `memresp1_msg`, `memresp1_val`: same as port 0, for dmem.
- `memreq_msg`  out  `VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)`  request to memory.
- `memreq_val`  out  1  request to memory valid.
- `memreq_rdy`  in  1  memory accepts request.
- `memresp_msg`  in  `VC_MEM_RESP_MSG_SZ(p_data_sz)`  memory response.
- `memresp_val`  in  1  memory response valid.
- `memresp_rdy`  out  1  constant 1 outside reset; responses are never back-pressured.
- `err`  out  1  sticky protocol error.

## Operation
- State:
  - `prio`: 1 bit, the port favoured on conflict.
  - ID queue: circular FIFO of 1-bit port IDs with head pointer, tail pointer and count.
  - `err`.
- Grant (combinational):
  - If only one `memreqN_val` is high, that port is granted.
  - If both are high, port `prio` is granted.
  - If neither is high, no grant.
- Request forwarding:
  - `memreq_val = (memreq0_val | memreq1_val) & !full`.
  - `memreq_msg` is the granted port's message, passed through unmodified.
  - `memreqN_rdy = grantN & memreq_rdy & !full`.
  - The ungranted port's `rdy` is 0.
- Fire: a request fires when `memreq_val & memreq_rdy`. On fire:
  - Push the granted ID at the tail.
  - Set `prio` to the non-granted port.
- If no request fires, `prio` holds.
- Response routing:
  - When `memresp_val` is high and the queue is non-empty, pop the head.
  - Drive `memresp<head>_val = 1`, with `memresp<head>_msg = memresp_msg`.
  - The other port's `val` is 0.
  - Both response messages carry `memresp_msg` at all times; only the `val` signals are steered.
- Push and pop in the same cycle: both take effect and the count is unchanged.
- Full (`count == p_max_outstanding`):
  - No fire, even if a pop happens in the same cycle.
  - This keeps `memreq_val` independent of `memresp_val`.
- Empty queue with `memresp_val` high:
  - The response is dropped; both `memrespN_val` stay 0.
  - `err` is set and stays set until reset.
- Pointers wrap modulo `p_max_outstanding`. Count ranges over 0..`p_max_outstanding`, so its width is log2(depth)+1.

## Timing
- Request path: zero-cycle combinational (val/msg/rdy); no added latency.
- Response path: zero-cycle combinational (val/msg).
- Request-to-response latency is set solely by the memory.
- Responses are assumed in order; the memory guarantees this.
- Reset values, applied immediately because reset is asynchronous:
  - `prio` = 0 (imem favoured).
  - Queue empty.
  - `err` = 0.
- While `reset` is high, all of these are forced to 0: `memreq_val`, `memreq0_rdy`, `memreq1_rdy`, `memresp0_val`, `memresp1_val`, `memresp_rdy`.
- Reset asserted mid-operation: in-flight IDs are discarded. The memory is reset in the same or an earlier cycle, so no stale responses arrive.
- Under a continuous conflict, grants strictly alternate 0,1,0,1…

## Configuration
- Macro: `RISCVVEC_MEM_ARB_STATS_EN`.
- Defined: three 32-bit counters, cleared on reset and readable hierarchically by the simulator:
  - `num_grant0`: increments on each port-0 fire.
  - `num_grant1`: increments on each port-1 fire.
  - `num_conflict`: increments on each cycle where both ports are valid.
  - Counters wrap at 2^32.
- Undefined: the counters are not built; functional behaviour is identical.

## Structure
- The `VC_MEM_REQ_MSG_SZ` / `VC_MEM_RESP_MSG_SZ` macros come from the shared vc memory-message include; no new typedefs.
- Port-ID constants (`ARB_PORT_IMEM = 1'b0`, `ARB_PORT_DMEM = 1'b1`) go in the shared riscvvec package.
- Sub-module `riscvvec_mem_arb_idq`:
  - Parameterised depth-`p_max_outstanding`, 1-bit-wide FIFO.
  - Ports: enq_val, enq_bits, deq_val, deq_bits, full, empty.
  - Pop is unconditional when requested; the parent guarantees non-empty.

## Test plan
- Port 0 only, `memreq_rdy=1`, addresses 0x100/0x104/0x108; memory returns data 0xA/0xB/0xC → `memresp0_val` pulses with 0xA, 0xB, 0xC in order; `memresp1_val` stays 0.
- Both ports valid continuously for 6 cycles, `memreq_rdy=1` → grant order 0,1,0,1,0,1; ID queue order matches; each response reaches the issuing port.
- Depth 4, no responses returned, 5 requests offered → 4 fire; on the 5th, `memreq_val=0` and both `rdy=0` until a response pops.
- `memresp_val` pulse with the queue empty → no `memrespN_val`; `err=1` and stays 1 until reset.
- Full queue with a response arriving → pop occurs, no push that cycle; push succeeds the next cycle.
- Reset asserted mid-stream with 3 requests outstanding → outputs go to 0 immediately; after release, count=0 and `prio=0`; with `RISCVVEC_MEM_ARB_STATS_EN` defined, the counters read 0.
